// File: rtl/sdrc_arb_pkg.sv
// Shared types and helpers for the SDRAM-controller Wishbone arbiter.
package sdrc_arb_pkg;

    // Arbiter ownership state: IDLE = no owner, BUSY = one master owns the slave port.
    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    // Wishbone cycle type identifiers. The arbiter forwards cti untouched;
    // bursts stay atomic because release only looks at cyc.
    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    // Widest master count the arbiter supports.
    localparam int MAX_M = 8;

    // Round-robin pick: first requesting index searching last+1, last+2, ...
    // modulo num_m. Returns 0 when nothing requests; callers qualify with |req.
    function automatic int rr_pick(input logic [MAX_M-1:0] req,
                                   input int              last,
                                   input int              num_m);
        int pick;
        int idx;
        pick = 0;
        // Walk from the farthest candidate back to the nearest so the nearest wins.
        for (int i = num_m; i >= 1; i--) begin
            idx = (last + i) % num_m;
            if (req[idx]) begin
                pick = idx;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/sdrc_wb_arbiter_rr_pick.sv
// Combinational round-robin priority encoder over NUM_M request lines.
module sdrc_rr_pick
    import sdrc_arb_pkg::*;
#(
    parameter int NUM_M = 4,
    parameter int IW    = 2
) (
    input  logic [NUM_M-1:0] req_i,
    input  logic [IW-1:0]    last_i,
    output logic [IW-1:0]    idx_o,
    output logic             valid_o
);

    logic [MAX_M-1:0] req_ext;

    // Widen the request vector and pick the next requester after last_i.
    always_comb begin
        req_ext                = '0;
        req_ext[NUM_M-1:0]     = req_i;
        idx_o                  = IW'(rr_pick(req_ext, int'(last_i), NUM_M));
        valid_o                = |req_i;
    end

endmodule

// File: rtl/sdrc_wb_arbiter.sv
// Round-robin Wishbone arbiter sharing the sdrc_top slave port between NUM_M
// masters. Ownership lasts for a whole Wishbone cycle (cyc high), so bursts
// are never split. A hold watchdog flags a granted cycle that stalls too long.
//
// Handshake: a master presents a request with cyc&stb; it is served only while
// it owns the port, and each beat completes on the cycle its ack is high.
// Non-owners see ack low and simply hold their request.
module sdrc_wb_arbiter
    import sdrc_arb_pkg::*;
#(
    parameter int NUM_M  = 4,
    parameter int APP_AW = 26,
    parameter int APP_DW = 32,
    parameter int TO_CYC = 1024
) (
    input  logic                         sys_clk,
    input  logic                         resetn,
    input  logic [NUM_M-1:0]             m_cyc_i,
    input  logic [NUM_M-1:0]             m_stb_i,
    input  logic [NUM_M-1:0]             m_we_i,
    input  logic [NUM_M*APP_AW-1:0]      m_addr_i,
    input  logic [NUM_M*APP_DW-1:0]      m_dat_i,
    input  logic [NUM_M*(APP_DW/8)-1:0]  m_sel_i,
    input  logic [NUM_M*3-1:0]           m_cti_i,
    output logic [NUM_M-1:0]             m_ack_o,
    output logic [APP_DW-1:0]            m_dat_o,
    output logic                         s_cyc_o,
    output logic                         s_stb_o,
    output logic                         s_we_o,
    output logic [APP_AW-1:0]            s_addr_o,
    output logic [APP_DW-1:0]            s_dat_o,
    output logic [APP_DW/8-1:0]          s_sel_o,
    output logic [2:0]                   s_cti_o,
    input  logic                         s_ack_i,
    input  logic [APP_DW-1:0]            s_dat_i,
    output logic [NUM_M-1:0]             grant_o,
    output logic                         busy_o,
    output logic                         timeout_o
);

    localparam int IW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
    localparam int SW = APP_DW / 8;
    localparam int CW = $clog2(TO_CYC + 1);

    arb_state_e        state_q, state_d;
    logic [IW-1:0]     grant_q, grant_d;
    logic [IW-1:0]     last_q, last_d;
    logic [CW-1:0]     wd_q, wd_d;
    logic              timeout_q, timeout_d;

    logic [NUM_M-1:0]  req;
    logic [IW-1:0]     pick_idx;
    logic              pick_valid;
    logic              own_cyc;

    assign req = m_cyc_i & m_stb_i;

    sdrc_rr_pick #(
        .NUM_M (NUM_M),
        .IW    (IW)
    ) u_pick (
        .req_i   (req),
        .last_i  (last_q),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    // cyc of the current owner; decides when ownership ends.
    always_comb begin
        own_cyc = 1'b0;
        for (int k = 0; k < NUM_M; k++) begin
            if (grant_q == IW'(k)) begin
                own_cyc = m_cyc_i[k];
            end
        end
    end

    // Next-state: grant on request in IDLE, release on owner cyc low, watchdog.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        wd_d      = wd_q;
        timeout_d = timeout_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    state_d = ARB_BUSY;
                    grant_d = pick_idx;
                    wd_d    = '0;
                end
            end
            ARB_BUSY: begin
                // Any ack proves the slave is alive; otherwise count, saturating.
                if (s_ack_i) begin
                    wd_d = '0;
                end else if (wd_q < CW'(TO_CYC)) begin
                    wd_d = wd_q + CW'(1);
                end
                // An ack arriving with cyc low still reaches the owner via the
                // output mux; the release happens on this same edge.
                if (!own_cyc) begin
                    state_d = ARB_IDLE;
                    last_d  = grant_q;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
        if (wd_d == CW'(TO_CYC)) begin
            timeout_d = 1'b1;
        end
    end

    // State, ownership and watchdog registers; async reset makes master 0 win first.
    always_ff @(posedge sys_clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ARB_IDLE;
            grant_q   <= '0;
            last_q    <= IW'(NUM_M - 1);
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end

    // Slave-side mux and ack routing; everything is quiet while IDLE.
    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_addr_o = '0;
        s_dat_o  = '0;
        s_sel_o  = '0;
        s_cti_o  = CTI_CLASSIC;
        grant_o  = '0;
        m_ack_o  = '0;
        if (state_q == ARB_BUSY) begin
            for (int k = 0; k < NUM_M; k++) begin
                if (grant_q == IW'(k)) begin
                    s_cyc_o    = m_cyc_i[k];
                    s_stb_o    = m_stb_i[k];
                    s_we_o     = m_we_i[k];
                    s_addr_o   = m_addr_i[k*APP_AW +: APP_AW];
                    s_dat_o    = m_dat_i[k*APP_DW +: APP_DW];
                    s_sel_o    = m_sel_i[k*SW +: SW];
                    s_cti_o    = m_cti_i[k*3 +: 3];
                    grant_o[k] = 1'b1;
                    m_ack_o[k] = s_ack_i;
                end
            end
        end
    end

    assign m_dat_o   = s_dat_i;
    assign busy_o    = (state_q == ARB_BUSY);
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_sdrc_wb_arbiter.sv
// Bench for sdrc_wb_arbiter: vector table, hand-written corner sequences and
// randomized traffic, all checked against a cycle-level ownership model.
module tb_sdrc_wb_arbiter;
    import sdrc_arb_pkg::*;

    localparam int NUM_M  = 4;
    localparam int AW     = 26;
    localparam int DW     = 32;
    localparam int SW     = DW / 8;
    localparam int TO_CYC = 1024;

    logic                  sys_clk;
    logic                  resetn;
    logic [NUM_M-1:0]      m_cyc, m_stb, m_we;
    logic [NUM_M*AW-1:0]   m_addr;
    logic [NUM_M*DW-1:0]   m_dat;
    logic [NUM_M*SW-1:0]   m_sel;
    logic [NUM_M*3-1:0]    m_cti;
    logic [NUM_M-1:0]      m_ack_o;
    logic [DW-1:0]         m_dat_o;
    logic                  s_cyc_o, s_stb_o, s_we_o;
    logic [AW-1:0]         s_addr_o;
    logic [DW-1:0]         s_dat_o;
    logic [SW-1:0]         s_sel_o;
    logic [2:0]            s_cti_o;
    logic                  s_ack;
    logic [DW-1:0]         s_dat;
    logic [NUM_M-1:0]      grant_o;
    logic                  busy_o;
    logic                  timeout_o;

    sdrc_wb_arbiter #(
        .NUM_M  (NUM_M),
        .APP_AW (AW),
        .APP_DW (DW),
        .TO_CYC (TO_CYC)
    ) dut (
        .sys_clk   (sys_clk),
        .resetn    (resetn),
        .m_cyc_i   (m_cyc),
        .m_stb_i   (m_stb),
        .m_we_i    (m_we),
        .m_addr_i  (m_addr),
        .m_dat_i   (m_dat),
        .m_sel_i   (m_sel),
        .m_cti_i   (m_cti),
        .m_ack_o   (m_ack_o),
        .m_dat_o   (m_dat_o),
        .s_cyc_o   (s_cyc_o),
        .s_stb_o   (s_stb_o),
        .s_we_o    (s_we_o),
        .s_addr_o  (s_addr_o),
        .s_dat_o   (s_dat_o),
        .s_sel_o   (s_sel_o),
        .s_cti_o   (s_cti_o),
        .s_ack_i   (s_ack),
        .s_dat_i   (s_dat),
        .grant_o   (grant_o),
        .busy_o    (busy_o),
        .timeout_o (timeout_o)
    );

    // ---------------- clock ----------------
    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Ownership view: owner = -1 when nobody holds the port.
    int mo_owner;
    int mo_last;
    int mo_wd;
    bit mo_to;

    task automatic model_reset();
        mo_owner = -1;
        mo_last  = NUM_M - 1;
        mo_wd    = 0;
        mo_to    = 1'b0;
    endtask

    task automatic model_check(input string tag);
        logic [NUM_M-1:0] e_grant, e_ack;
        logic             e_cyc, e_stb, e_we;
        logic [AW-1:0]    e_addr;
        logic [DW-1:0]    e_dat;
        logic [SW-1:0]    e_sel;
        logic [2:0]       e_cti;
        e_grant = '0; e_ack = '0; e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0;
        e_addr = '0; e_dat = '0; e_sel = '0; e_cti = 3'b000;
        if (mo_owner >= 0) begin
            e_grant[mo_owner] = 1'b1;
            e_ack[mo_owner]   = s_ack;
            e_cyc  = m_cyc[mo_owner];
            e_stb  = m_stb[mo_owner];
            e_we   = m_we[mo_owner];
            e_addr = m_addr[mo_owner*AW +: AW];
            e_dat  = m_dat[mo_owner*DW +: DW];
            e_sel  = m_sel[mo_owner*SW +: SW];
            e_cti  = m_cti[mo_owner*3 +: 3];
        end
        chk({tag, ".grant"},   grant_o,   e_grant);
        chk({tag, ".busy"},    busy_o,    (mo_owner >= 0));
        chk({tag, ".ack"},     m_ack_o,   e_ack);
        chk({tag, ".s_cyc"},   s_cyc_o,   e_cyc);
        chk({tag, ".s_stb"},   s_stb_o,   e_stb);
        chk({tag, ".s_we"},    s_we_o,    e_we);
        chk({tag, ".s_addr"},  s_addr_o,  e_addr);
        chk({tag, ".s_dat"},   s_dat_o,   e_dat);
        chk({tag, ".s_sel"},   s_sel_o,   e_sel);
        chk({tag, ".s_cti"},   s_cti_o,   e_cti);
        chk({tag, ".m_dat"},   m_dat_o,   s_dat);
        chk({tag, ".timeout"}, timeout_o, mo_to);
    endtask

    // Advance the model across one rising edge using the inputs held over it.
    task automatic model_step();
        int idx;
        if (mo_owner < 0) begin
            if ((m_cyc & m_stb) != '0) begin
                for (int i = 1; i <= NUM_M; i++) begin
                    idx = (mo_last + i) % NUM_M;
                    if (m_cyc[idx] && m_stb[idx]) begin
                        mo_owner = idx;
                        break;
                    end
                end
                mo_wd = 0;
            end
        end else begin
            if (s_ack) mo_wd = 0;
            else if (mo_wd < TO_CYC) mo_wd = mo_wd + 1;
            if (mo_wd == TO_CYC) mo_to = 1'b1;
            if (!m_cyc[mo_owner]) begin
                mo_last  = mo_owner;
                mo_owner = -1;
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    // Called at a falling edge with inputs already applied.
    task automatic cycle(input string tag);
        #1;
        model_check(tag);
        @(posedge sys_clk);
        model_step();
        @(negedge sys_clk);
    endtask

    task automatic clear_inputs();
        m_cyc = '0; m_stb = '0; m_we = '0; m_addr = '0; m_dat = '0;
        m_sel = '0; m_cti = '0; s_ack = 1'b0; s_dat = '0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        resetn = 1'b0;
        @(negedge sys_clk);
        @(negedge sys_clk);
        resetn = 1'b1;
        model_reset();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit               do_rst;
        logic [NUM_M-1:0] cyc;
        logic             ack;
        logic [NUM_M-1:0] e_grant;
        logic             e_busy;
        logic [NUM_M-1:0] e_ack;
    } vec_t;

    vec_t tab[$];

    task automatic add_vec(input bit r, input logic [3:0] c, input logic a,
                           input logic [3:0] g, input logic b, input logic [3:0] k);
        vec_t v;
        v.do_rst = r; v.cyc = c; v.ack = a; v.e_grant = g; v.e_busy = b; v.e_ack = k;
        tab.push_back(v);
    endtask

    initial begin
        resetn = 1'b0;
        clear_inputs();
        model_reset();
        @(negedge sys_clk);
        @(negedge sys_clk);
        #1;
        chk("reset.grant",   grant_o,   4'b0000);
        chk("reset.busy",    busy_o,    1'b0);
        chk("reset.timeout", timeout_o, 1'b0);
        chk("reset.s_cyc",   s_cyc_o,   1'b0);

        // Single master classic write, then a three-way tie after reset.
        add_vec(1, 4'b0100, 0, 4'b0000, 0, 4'b0000);
        add_vec(0, 4'b0100, 1, 4'b0100, 1, 4'b0100);
        add_vec(0, 4'b0100, 0, 4'b0100, 1, 4'b0000);
        add_vec(0, 4'b0000, 0, 4'b0100, 1, 4'b0000);
        add_vec(0, 4'b0000, 0, 4'b0000, 0, 4'b0000);
        add_vec(1, 4'b1011, 0, 4'b0000, 0, 4'b0000);
        add_vec(0, 4'b1011, 1, 4'b0001, 1, 4'b0001);
        add_vec(0, 4'b1010, 1, 4'b0001, 1, 4'b0001);
        add_vec(0, 4'b1010, 0, 4'b0000, 0, 4'b0000);
        add_vec(0, 4'b1010, 1, 4'b0010, 1, 4'b0010);
        add_vec(0, 4'b1000, 0, 4'b0010, 1, 4'b0000);
        add_vec(0, 4'b1000, 0, 4'b0000, 0, 4'b0000);
        add_vec(0, 4'b1000, 1, 4'b1000, 1, 4'b1000);
        add_vec(0, 4'b0000, 0, 4'b1000, 1, 4'b0000);
        add_vec(0, 4'b0000, 0, 4'b0000, 0, 4'b0000);

        foreach (tab[i]) begin
            if (tab[i].do_rst) apply_reset();
            m_addr[0*AW +: AW] = 26'h0000100;
            m_addr[1*AW +: AW] = 26'h0000200;
            m_addr[2*AW +: AW] = 26'h0000040;
            m_addr[3*AW +: AW] = 26'h0000300;
            m_dat[2*DW +: DW]  = 32'hDEADBEEF;
            m_we               = 4'b0100;
            m_sel              = '1;
            m_cyc = tab[i].cyc;
            m_stb = tab[i].cyc;
            s_ack = tab[i].ack;
            s_dat = 32'h1000_0000 + 32'(i);
            #1;
            chk($sformatf("tab%0d.grant", i), grant_o, tab[i].e_grant);
            chk($sformatf("tab%0d.busy", i),  busy_o,  tab[i].e_busy);
            chk($sformatf("tab%0d.ack", i),   m_ack_o, tab[i].e_ack);
            if (tab[i].e_grant[2]) begin
                chk($sformatf("tab%0d.addr", i), s_addr_o, 26'h40);
                chk($sformatf("tab%0d.wdat", i), s_dat_o,  32'hDEADBEEF);
            end
            cycle($sformatf("tab%0d", i));
        end

        // Burst by master 1 while master 0 waits.
        apply_reset();
        m_addr[1*AW +: AW] = 26'h0000100;
        m_cyc = 4'b0010; m_stb = 4'b0010;
        m_cti[1*3 +: 3] = CTI_INCR;
        cycle("t3.arb");
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
        for (int b = 0; b < 8; b++) begin
            m_cti[1*3 +: 3]    = (b == 7) ? CTI_EOB : CTI_INCR;
            m_addr[1*AW +: AW] = 26'h0000100 + 26'(4 * b);
            s_ack = 1'b1;
            s_dat = $urandom;
            #1;
            chk($sformatf("t3.beat%0d.grant", b), grant_o, 4'b0010);
            chk($sformatf("t3.beat%0d.ack0", b), m_ack_o[0], 1'b0);
            cycle($sformatf("t3.beat%0d", b));
        end
        m_cyc[1] = 1'b0; m_stb[1] = 1'b0; s_ack = 1'b0;
        cycle("t3.rel");
        cycle("t3.idle");
        #1;
        chk("t3.next_grant", grant_o, 4'b0001);

        // Master 0 re-requests right after its release while master 3 waits.
        m_cyc[3] = 1'b1; m_stb[3] = 1'b1;
        s_ack = 1'b1;
        cycle("t4.ack");
        s_ack = 1'b0; m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        cycle("t4.rel");
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
        cycle("t4.idle");
        #1;
        chk("t4.grant3", grant_o, 4'b1000);
        m_cyc = '0; m_stb = '0;
        cycle("t4.drop");
        cycle("t4.end");

        // Watchdog: master 1 stalls with no ack.
        apply_reset();
        m_cyc = 4'b0010; m_stb = 4'b0010;
        cycle("t5.arb");
        for (int n = 1; n < TO_CYC; n++) cycle("t5.stall");
        #1;
        chk("t5.timeout_before", timeout_o, 1'b0);
        cycle("t5.last");
        #1;
        chk("t5.timeout_set", timeout_o, 1'b1);
        chk("t5.grant_held", grant_o, 4'b0010);
        s_ack = 1'b1;
        cycle("t5.ack");
        s_ack = 1'b0; m_cyc = '0; m_stb = '0;
        cycle("t5.rel");
        cycle("t5.idle");
        #1;
        chk("t5.timeout_sticky", timeout_o, 1'b1);

        // Asynchronous reset in the middle of a burst.
        apply_reset();
        m_cyc = 4'b0010; m_stb = 4'b0010; m_cti[1*3 +: 3] = CTI_INCR;
        cycle("t6.arb");
        s_ack = 1'b1;
        cycle("t6.beat0");
        cycle("t6.beat1");
        #2;
        resetn = 1'b0;
        #1;
        chk("t6.s_cyc", s_cyc_o, 1'b0);
        chk("t6.s_stb", s_stb_o, 1'b0);
        chk("t6.grant", grant_o, 4'b0000);
        chk("t6.busy",  busy_o,  1'b0);
        chk("t6.ack",   m_ack_o, 4'b0000);
        model_reset();
        clear_inputs();
        m_cyc = 4'b0101; m_stb = 4'b0101;
        @(negedge sys_clk);
        resetn = 1'b1;
        cycle("t6.tie");
        #1;
        chk("t6.grant0", grant_o, 4'b0001);
        m_cyc = '0; m_stb = '0;
        cycle("t6.drop");

        // Randomized traffic against the model.
        apply_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < NUM_M; k++) begin
                m_cyc[k] = ($urandom_range(0, 9) < 7);
                m_stb[k] = ($urandom_range(0, 9) < 8);
                m_we[k]  = $urandom_range(0, 1);
                m_addr[k*AW +: AW] = AW'($urandom);
                m_dat[k*DW +: DW]  = $urandom;
                m_sel[k*SW +: SW]  = SW'($urandom);
                m_cti[k*3 +: 3]    = 3'($urandom);
            end
            s_ack = ($urandom_range(0, 2) == 0);
            s_dat = $urandom;
            cycle("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
